spi_seq_ctrl: RTL and testbench

Parametrised top-level sequencer for the SPI front end. It walks an ordered list of NUM_INIT configuration transfers (amplifier, references, etc.), then runs ADC acquisition transfers in single-shot or continuous mode at a programmable period. It adds per-transfer timeout with an error state, stop/restart, and skipping of re-initialisation. It drives the SPI transfer engine via a start/done handshake and selects the target device on each transfer.

---
 rtl/spi_seq_ctrl_if.sv | 11 +
 rtl/spi_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_spi_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_seq_ctrl_if.sv
// rtl/spi_seq_ctrl_if.sv - start/done handshake and device select between sequencer and SPI transfer engine
interface spi_seq_ctrl_if #(
    parameter int DEV_W = 2
);
    logic             xfer_start;
    logic             xfer_done;
    logic [DEV_W-1:0] dev_sel;

    modport master (output xfer_start, output dev_sel, input xfer_done);
    modport slave  (input xfer_start, input dev_sel, output xfer_done);
endinterface

// File: rtl/spi_seq_ctrl.sv
// rtl/spi_seq_ctrl.sv - SPI front-end sequencer: init transfer list, then single/continuous acquisition
module spi_seq_ctrl #(
    parameter int NUM_INIT = 2,
    parameter int DEV_W    = 2,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 1023,
    parameter int TO_W     = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                mode,
    input  logic [PERIOD_W-1:0] period,
    spi_seq_ctrl_if.master      bus,
    output logic                busy,
    output logic                init_ok,
    output logic                err,
    output logic                acq_done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_REQ,
        S_INIT_WAIT,
        S_ACQ_REQ,
        S_ACQ_WAIT,
        S_PERIOD_WAIT,
        S_ERROR
    } state_t;

    localparam logic [DEV_W-1:0] ACQ_DEV  = DEV_W'(NUM_INIT);
    localparam logic [DEV_W-1:0] LAST_IDX = DEV_W'(NUM_INIT - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);

    state_t              state;
    logic [DEV_W-1:0]    idx;
    logic [TO_W-1:0]     timer;
    logic [PERIOD_W-1:0] pcnt;
    logic                stop_pend;
    logic                stop_req;
    logic                timed_out;

    // A stop arriving in the same cycle as the done still counts as pending.
    assign stop_req  = stop_pend | stop;
    assign timed_out = (timer == TO_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            timer     <= '0;
            pcnt      <= '0;
            stop_pend <= 1'b0;
            init_ok   <= 1'b0;
            acq_done  <= 1'b0;
        end else begin
            acq_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        stop_pend <= stop;
                        if (init_ok) begin
                            state <= S_ACQ_REQ;
                        end else begin
                            idx   <= '0;
                            state <= S_INIT_REQ;
                        end
                    end
                end
                S_INIT_REQ: begin
                    timer     <= '0;
                    stop_pend <= stop_req;
                    state     <= S_INIT_WAIT;
                end
                S_INIT_WAIT: begin
                    stop_pend <= stop_req;
                    if (bus.xfer_done) begin
                        if (idx == LAST_IDX) begin
                            init_ok <= 1'b1;
                        end
                        if (stop_req) begin
                            stop_pend <= 1'b0;
                            state     <= S_IDLE;
                        end else if (idx == LAST_IDX) begin
                            state <= S_ACQ_REQ;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_INIT_REQ;
                        end
                    end else if (timed_out) begin
                        stop_pend <= 1'b0;
                        init_ok   <= 1'b0;
                        state     <= S_ERROR;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_ACQ_REQ: begin
                    timer     <= '0;
                    stop_pend <= stop_req;
                    state     <= S_ACQ_WAIT;
                end
                S_ACQ_WAIT: begin
                    stop_pend <= stop_req;
                    if (bus.xfer_done) begin
                        acq_done <= 1'b1;
                        if (stop_req || !mode) begin
                            stop_pend <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            pcnt  <= period;
                            state <= S_PERIOD_WAIT;
                        end
                    end else if (timed_out) begin
                        stop_pend <= 1'b0;
                        init_ok   <= 1'b0;
                        state     <= S_ERROR;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_PERIOD_WAIT: begin
                    if (stop) begin
                        stop_pend <= 1'b0;
                        state     <= S_IDLE;
                    end else if (pcnt == '0) begin
                        state <= S_ACQ_REQ;
                    end else begin
                        pcnt <= pcnt - 1'b1;
                    end
                end
                S_ERROR: begin
                    init_ok <= 1'b0;
                    if (start) begin
                        idx       <= '0;
                        stop_pend <= stop;
                        state     <= S_INIT_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.xfer_start = (state == S_INIT_REQ) || (state == S_ACQ_REQ);
    assign busy           = (state != S_IDLE) && (state != S_ERROR);
    assign err            = (state == S_ERROR);

    always_comb begin
        bus.dev_sel = '0;
        if (state == S_INIT_REQ || state == S_INIT_WAIT) begin
            bus.dev_sel = idx;
        end else if (state == S_ACQ_REQ || state == S_ACQ_WAIT || state == S_PERIOD_WAIT) begin
            bus.dev_sel = ACQ_DEV;
        end
    end
endmodule

// File: tb/tb_spi_seq_ctrl.sv
// tb/tb_spi_seq_ctrl.sv - scoreboard bench for spi_seq_ctrl with a scripted SPI engine responder
module tb_spi_seq_ctrl;
    localparam int NUM_INIT = 2;
    localparam int DEV_W    = 2;
    localparam int PERIOD_W = 16;
    localparam int TIMEOUT  = 15;
    localparam int TO_W     = 4;

    localparam int EV_XS  = 0;
    localparam int EV_ACQ = 1;
    localparam int EV_ERR = 2;

    typedef struct {
        int kind;
        int dev;
        int cyc;
    } evt_t;

    typedef struct {
        int cyc;
        int busy;
        int init_ok;
        int err;
        int xs;
        int dev;
        int acq;
    } lvl_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic                mode = 1'b0;
    logic [PERIOD_W-1:0] period = '0;
    logic                busy;
    logic                init_ok;
    logic                err;
    logic                acq_done;

    spi_seq_ctrl_if #(.DEV_W(DEV_W)) bus ();

    spi_seq_ctrl #(
        .NUM_INIT(NUM_INIT),
        .DEV_W   (DEV_W),
        .PERIOD_W(PERIOD_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .period  (period),
        .bus     (bus),
        .busy    (busy),
        .init_ok (init_ok),
        .err     (err),
        .acq_done(acq_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    evt_t eq[$];
    lvl_t lq[$];
    int   n_checks = 0;
    int   n_pass = 0;
    bit   fin = 1'b0;
    int   lat = 5;
    bit   drop = 1'b0;

    // SPI engine model: answers each xfer_start with a one-cycle done lat cycles later.
    initial begin : responder
        bit pend;
        int due;
        pend = 1'b0;
        due  = 0;
        bus.xfer_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 1'b0;
            end else if (bus.xfer_start && !drop) begin
                pend = 1'b1;
                due  = cyc + lat;
            end
            @(posedge clk);
            #1;
            if (!rst) pend = 1'b0;
            bus.xfer_done = pend && (cyc == due);
            if (bus.xfer_done) pend = 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    endtask

    task automatic match_evt(input int kind, input int dev);
        evt_t e;
        if (eq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event @cycle %0d: got event kind %0d, required none", cyc, kind);
        end else begin
            e = eq.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.cyc);
            if (kind == EV_XS && e.kind == EV_XS) check("xfer_dev_sel", dev, e.dev);
        end
    endtask

    initial begin : monitor
        bit   err_q;
        lvl_t l;
        err_q = 1'b0;
        forever begin
            @(negedge clk);
            if (acq_done) match_evt(EV_ACQ, 0);
            if (bus.xfer_start) match_evt(EV_XS, int'(bus.dev_sel));
            if (err && !err_q) match_evt(EV_ERR, 0);
            err_q = err;
            while (lq.size() > 0 && lq[0].cyc <= cyc) begin
                l = lq.pop_front();
                check("lvl_busy", int'(busy), l.busy);
                check("lvl_init_ok", int'(init_ok), l.init_ok);
                check("lvl_err", int'(err), l.err);
                check("lvl_xfer_start", int'(bus.xfer_start), l.xs);
                if (l.dev >= 0) check("lvl_dev_sel", int'(bus.dev_sel), l.dev);
                check("lvl_acq_done", int'(acq_done), l.acq);
            end
            if (fin || cyc > 4000) begin
                check("finished_in_budget", int'(fin), 1);
                check("leftover_events", eq.size(), 0);
                check("leftover_levels", lq.size(), 0);
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $finish;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    task automatic pev(input int kind, input int dev, input int c);
        evt_t e;
        e.kind = kind;
        e.dev  = dev;
        e.cyc  = c;
        eq.push_back(e);
    endtask

    task automatic plv(input int c, input int b, input int io, input int er,
                       input int xs, input int dv, input int ac);
        lvl_t l;
        l.cyc = c; l.busy = b; l.init_ok = io; l.err = er;
        l.xs = xs; l.dev = dv; l.acq = ac;
        lq.push_back(l);
    endtask

    task automatic pulse_start(input bit with_stop);
        start = 1'b1;
        stop  = with_stop;
        step();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin : stimulus
        int t;
        plv(2, 0, 0, 0, 0, 0, 0);
        wait_cyc(3);
        rst = 1'b1;

        // Init + single acquisition
        wait_cyc(5);
        mode = 1'b0; period = 16'd3; t = cyc;
        pev(EV_XS, 0, t + 1); pev(EV_XS, 1, t + 7); pev(EV_XS, 2, t + 13); pev(EV_ACQ, 0, t + 19);
        plv(t + 1, 1, 0, 0, 1, 0, 0);
        plv(t + 12, 1, 0, 0, 0, 1, 0);
        plv(t + 13, 1, 1, 0, 1, 2, 0);
        plv(t + 19, 0, 1, 0, 0, 0, 1);
        pulse_start(1'b0);
        wait_cyc(t + 25);

        // Continuous, period 3, stop during ACQ_WAIT
        mode = 1'b1; t = cyc;
        pev(EV_XS, 2, t + 1);  pev(EV_ACQ, 0, t + 7);
        pev(EV_XS, 2, t + 11); pev(EV_ACQ, 0, t + 17);
        pev(EV_XS, 2, t + 21); pev(EV_ACQ, 0, t + 27);
        plv(t + 8, 1, 1, 0, 0, 2, 0);
        plv(t + 27, 0, 1, 0, 0, 0, 1);
        plv(t + 30, 0, 1, 0, 0, 0, 0);
        pulse_start(1'b0);
        wait_cyc(t + 22);
        stop = 1'b1; step(); stop = 1'b0;
        wait_cyc(t + 35);

        // Stop during PERIOD_WAIT
        t = cyc;
        pev(EV_XS, 2, t + 1); pev(EV_ACQ, 0, t + 7);
        plv(t + 8, 1, 1, 0, 0, 2, 0);
        plv(t + 9, 0, 1, 0, 0, 0, 0);
        pulse_start(1'b0);
        wait_cyc(t + 8);
        stop = 1'b1; step(); stop = 1'b0;
        wait_cyc(t + 20);

        // Async reset mid PERIOD_WAIT
        t = cyc;
        pev(EV_XS, 2, t + 1); pev(EV_ACQ, 0, t + 7);
        plv(t + 8, 0, 0, 0, 0, 0, 0);
        pulse_start(1'b0);
        wait_cyc(t + 8);
        rst = 1'b0;
        wait_cyc(t + 10);
        rst = 1'b1;
        wait_cyc(t + 13);

        // Async reset mid INIT_WAIT; start must run full init again
        mode = 1'b0; t = cyc;
        pev(EV_XS, 0, t + 1);
        plv(t + 2, 1, 0, 0, 0, 0, 0);
        plv(t + 3, 0, 0, 0, 0, 0, 0);
        pulse_start(1'b0);
        wait_cyc(t + 3);
        rst = 1'b0;
        wait_cyc(t + 5);
        rst = 1'b1;
        wait_cyc(t + 10);

        // Timeout on the second init transfer
        t = cyc;
        pev(EV_XS, 0, t + 1); pev(EV_XS, 1, t + 7); pev(EV_ERR, 0, t + 24);
        plv(t + 23, 1, 0, 0, 0, 1, 0);
        plv(t + 24, 0, 0, 1, 0, -1, 0);
        pulse_start(1'b0);
        wait_cyc(t + 3);
        drop = 1'b1;
        wait_cyc(t + 26);
        drop = 1'b0;

        // Restart from ERROR with done landing on timer==TIMEOUT
        lat = 16; t = cyc;
        pev(EV_XS, 0, t + 1); pev(EV_XS, 1, t + 18); pev(EV_XS, 2, t + 35); pev(EV_ACQ, 0, t + 52);
        plv(t + 1, 1, 0, 0, 1, 0, 0);
        plv(t + 17, 1, 0, 0, 0, 0, 0);
        plv(t + 52, 0, 1, 0, 0, 0, 1);
        pulse_start(1'b0);
        wait_cyc(t + 58);
        lat = 5;

        // Start and stop together in IDLE: exactly one acquisition even in continuous mode
        mode = 1'b1; t = cyc;
        pev(EV_XS, 2, t + 1); pev(EV_ACQ, 0, t + 7);
        plv(t + 7, 0, 1, 0, 0, 0, 1);
        plv(t + 12, 0, 1, 0, 0, 0, 0);
        pulse_start(1'b1);
        wait_cyc(t + 20);

        fin = 1'b1;
    end
endmodule
